vga_ram_multi: RTL and testbench

Parametrised successor to the VGA debug text RAM. It holds NUM_CH independent channels (e.g. instruction, register, data) of ROWS x COLS words each. Each channel has its own write port fed by the core's trace taps. The VGA renderer reads one display row at a time with registered, 1-cycle-latency reads. New features: per-channel scroll offset, per-row dirty (changed-since-last-display) flags, a post-reset/on-demand clear sequencer, and flagging of out-of-range writes.

---
 rtl/vga_ram_pkg.sv | 15 +
 rtl/vga_ram_channel.sv | 99 +++++++++
 rtl/vga_ram_multi.sv | 130 +++++++++++++
 tb/tb_vga_ram_multi.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_ram_pkg.sv
// Shared types, default geometry and row arithmetic for the multi-channel VGA debug RAM.
package vga_ram_pkg;

  typedef enum logic {CLEAR, IDLE} state_e;

  localparam int unsigned VGA_ROWS = 46;
  localparam int unsigned VGA_COLS = 2;
  localparam int unsigned VGA_CH   = 3;

  // Modulo for a sum of two values that are each below rows.
  function automatic int unsigned row_wrap(input int unsigned sum, input int unsigned rows);
    return (sum >= rows) ? (sum - rows) : sum;
  endfunction

endpackage

// File: rtl/vga_ram_channel.sv
// One display channel: word storage, dirty flags, scroll base, write decode and read-row mux.
module vga_ram_channel
  import vga_ram_pkg::*;
#(
  parameter int unsigned ROWS   = VGA_ROWS,
  parameter int unsigned COLS   = VGA_COLS,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned ROW_W  = $clog2(ROWS)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   busy_i,
  input  logic [ROW_W-1:0]       clr_row_i,
  input  logic                   wr_en_i,
  input  logic [ADDR_W-1:0]      wr_addr_i,
  input  logic [DATA_W-1:0]      wr_data_i,
  output logic                   wr_drop_o,
  input  logic [ROW_W-1:0]       rd_row_i,
  input  logic                   rd_clr_i,
  input  logic                   scroll_en_i,
  input  logic [ROW_W-1:0]       scroll_base_i,
  output logic [COLS*DATA_W-1:0] rd_data_o,
  output logic                   rd_dirty_o
);

  localparam int unsigned      COL_W  = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [ADDR_W-1:0] ROWS_A = ADDR_W'(ROWS);

  logic [DATA_W-1:0] mem_q [ROWS][COLS];
  logic [ROWS-1:0]   dirty_q;
  logic [ROW_W-1:0]  base_q;
  logic              wr_drop_q;

  logic [ADDR_W-1:0] rem;
  logic [COL_W-1:0]  col_idx;
  logic [ROW_W-1:0]  wr_row;
  logic              wr_ok;
  logic [ROW_W-1:0]  phys_row;

  // Address split by repeated subtraction; after COLS-1 steps the remainder is
  // below ROWS exactly when the address lies inside the channel.
  always_comb begin
    rem     = wr_addr_i;
    col_idx = '0;
    for (int unsigned k = 1; k < COLS; k++) begin
      if (rem >= ROWS_A) begin
        rem     = rem - ROWS_A;
        col_idx = col_idx + COL_W'(1);
      end
    end
    wr_row = rem[ROW_W-1:0];
    wr_ok  = wr_en_i & (rem < ROWS_A) & ~busy_i & ~rst_i;
  end

  // Scrolled physical row; forced to 0 for out-of-range rows so the mux stays in bounds.
  always_comb begin
    phys_row = '0;
    if (32'(rd_row_i) < ROWS)
      phys_row = ROW_W'(row_wrap(32'(rd_row_i) + 32'(base_q), ROWS));
  end

  // Storage: the clear sequencer owns the array while busy.
  always_ff @(posedge clk_i) begin
    if (busy_i && !rst_i) begin
      for (int unsigned k = 0; k < COLS; k++) mem_q[clr_row_i][k] <= '0;
    end else if (wr_ok) begin
      mem_q[wr_row][col_idx] <= wr_data_i;
    end
  end

  // Control state: dirty flags (write set beats read clear), scroll base, drop pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dirty_q   <= '0;
      base_q    <= '0;
      wr_drop_q <= 1'b0;
    end else begin
      wr_drop_q <= wr_en_i & ~wr_ok;
      if (scroll_en_i) base_q <= scroll_base_i;
      if (busy_i) begin
        dirty_q[clr_row_i] <= 1'b0;
      end else begin
        if (rd_clr_i) dirty_q[phys_row] <= 1'b0;
        if (wr_ok)    dirty_q[wr_row]   <= 1'b1;
      end
    end
  end

  // Read-row mux, column COLS-1 in the top bits.
  always_comb begin
    rd_data_o = '0;
    for (int unsigned k = 0; k < COLS; k++) rd_data_o[k*DATA_W +: DATA_W] = mem_q[phys_row][k];
    rd_dirty_o = dirty_q[phys_row];
  end

  assign wr_drop_o = wr_drop_q;

endmodule

// File: rtl/vga_ram_multi.sv
// Multi-channel VGA debug text RAM: clear sequencer, registered row read and output packing.
module vga_ram_multi
  import vga_ram_pkg::*;
#(
  parameter int unsigned NUM_CH = VGA_CH,
  parameter int unsigned ROWS   = VGA_ROWS,
  parameter int unsigned COLS   = VGA_COLS,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned ROW_W  = $clog2(ROWS),
  parameter int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CH-1:0]             wr_en,
  input  logic [NUM_CH*ADDR_W-1:0]      wr_addr,
  input  logic [NUM_CH*DATA_W-1:0]      wr_data,
  output logic [NUM_CH-1:0]             wr_drop,
  input  logic                          rd_en,
  input  logic [ROW_W-1:0]              rd_row,
  output logic                          rd_valid,
  output logic [NUM_CH*COLS*DATA_W-1:0] ram_out,
  output logic [NUM_CH-1:0]             dirty_out,
  input  logic                          scroll_en,
  input  logic [CH_W-1:0]               scroll_ch,
  input  logic [ROW_W-1:0]              scroll_base,
  input  logic                          clear_req,
  output logic                          busy
);

  localparam int unsigned RB = COLS*DATA_W;

  state_e                   state_q, state_d;
  logic [ROW_W-1:0]         ctr_q, ctr_d;
  logic                     rd_valid_q;
  logic [NUM_CH*RB-1:0]     ram_q, ram_d;
  logic [NUM_CH-1:0]        dirty_q;
  logic [RB-1:0]            ch_data [NUM_CH];
  logic [NUM_CH-1:0]        ch_dirty;
  logic                     rd_in_range, rd_clr, scroll_ok;

  assign busy        = (state_q == CLEAR);
  assign rd_in_range = (32'(rd_row) < ROWS);
  assign rd_clr      = rd_en & ~busy & rd_in_range;
  assign scroll_ok   = scroll_en & (32'(scroll_ch) < NUM_CH) & (32'(scroll_base) < ROWS);

  // Clear FSM state register; reset always restarts a full clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      ctr_q   <= '0;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
    end
  end

  // Clear FSM next state: sweep every row once, then wait for clear_req.
  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    case (state_q)
      CLEAR: begin
        if (32'(ctr_q) == ROWS - 1) begin
          state_d = IDLE;
          ctr_d   = '0;
        end else begin
          ctr_d = ctr_q + ROW_W'(1);
        end
      end
      IDLE: begin
        if (clear_req) begin
          state_d = CLEAR;
          ctr_d   = '0;
        end
      end
    endcase
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    vga_ram_channel #(
      .ROWS   (ROWS),
      .COLS   (COLS),
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .ROW_W  (ROW_W)
    ) u_ch (
      .clk_i         (clk),
      .rst_i         (rst),
      .busy_i        (busy),
      .clr_row_i     (ctr_q),
      .wr_en_i       (wr_en[c]),
      .wr_addr_i     (wr_addr[c*ADDR_W +: ADDR_W]),
      .wr_data_i     (wr_data[c*DATA_W +: DATA_W]),
      .wr_drop_o     (wr_drop[c]),
      .rd_row_i      (rd_row),
      .rd_clr_i      (rd_clr),
      .scroll_en_i   (scroll_ok && (32'(scroll_ch) == c)),
      .scroll_base_i (scroll_base),
      .rd_data_o     (ch_data[c]),
      .rd_dirty_o    (ch_dirty[c])
    );
  end

  // Output packing: channel 0 in the most significant slice.
  always_comb begin
    ram_d = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) ram_d[(NUM_CH-1-c)*RB +: RB] = ch_data[c];
  end

  // Read pipeline register; data holds when no read is issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      ram_q      <= '0;
      dirty_q    <= '0;
    end else begin
      rd_valid_q <= rd_en;
      if (rd_en) begin
        ram_q   <= rd_in_range ? ram_d : '0;
        dirty_q <= rd_in_range ? ch_dirty : '0;
      end
    end
  end

  assign rd_valid  = rd_valid_q;
  assign ram_out   = ram_q;
  assign dirty_out = dirty_q;

endmodule

// File: tb/tb_vga_ram_multi.sv
// Self-checking bench for vga_ram_multi against a behavioural row/column model.
module tb_vga_ram_multi;

  localparam int NUM_CH = 3;
  localparam int ROWS   = 46;
  localparam int COLS   = 2;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int ROW_W  = 6;
  localparam int CH_W   = 2;
  localparam int RB     = COLS*DATA_W;
  localparam int OW     = NUM_CH*RB;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic [NUM_CH-1:0]        wr_en = '0;
  logic [NUM_CH*ADDR_W-1:0] wr_addr = '0;
  logic [NUM_CH*DATA_W-1:0] wr_data = '0;
  logic [NUM_CH-1:0]        wr_drop;
  logic                     rd_en = 1'b0;
  logic [ROW_W-1:0]         rd_row = '0;
  logic                     rd_valid;
  logic [OW-1:0]            ram_out;
  logic [NUM_CH-1:0]        dirty_out;
  logic                     scroll_en = 1'b0;
  logic [CH_W-1:0]          scroll_ch = '0;
  logic [ROW_W-1:0]         scroll_base = '0;
  logic                     clear_req = 1'b0;
  logic                     busy;

  always #5 clk = ~clk;

  vga_ram_multi #(
    .NUM_CH (NUM_CH),
    .ROWS   (ROWS),
    .COLS   (COLS),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_drop     (wr_drop),
    .rd_en       (rd_en),
    .rd_row      (rd_row),
    .rd_valid    (rd_valid),
    .ram_out     (ram_out),
    .dirty_out   (dirty_out),
    .scroll_en   (scroll_en),
    .scroll_ch   (scroll_ch),
    .scroll_base (scroll_base),
    .clear_req   (clear_req),
    .busy        (busy)
  );

  // Reference model state
  logic [DATA_W-1:0] m_mem [NUM_CH][ROWS][COLS];
  bit                m_dirty [NUM_CH][ROWS];
  int                m_base [NUM_CH];
  int                clr_left, clr_idx;
  logic              e_valid, e_busy;
  logic [OW-1:0]     e_ram;
  logic [NUM_CH-1:0] e_dirty, e_drop;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Advance the model across one clock edge using the inputs currently applied.
  task automatic model_edge();
    bit          bz;
    int          phys, ai;
    logic [ADDR_W-1:0] a;
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        m_base[c] = 0;
        for (int r = 0; r < ROWS; r++) m_dirty[c][r] = 1'b0;
      end
      e_valid = 1'b0; e_ram = '0; e_dirty = '0; e_drop = '0;
      clr_left = ROWS; clr_idx = 0;
    end else begin
      bz = (clr_left > 0);
      e_valid = rd_en;
      if (rd_en) begin
        e_ram = '0; e_dirty = '0;
        if (int'(rd_row) < ROWS) begin
          for (int c = 0; c < NUM_CH; c++) begin
            phys = (int'(rd_row) + m_base[c]) % ROWS;
            for (int k = 0; k < COLS; k++)
              e_ram[(NUM_CH-1-c)*RB + k*DATA_W +: DATA_W] = m_mem[c][phys][k];
            e_dirty[c] = m_dirty[c][phys];
            if (!bz) m_dirty[c][phys] = 1'b0;
          end
        end
      end
      for (int c = 0; c < NUM_CH; c++) begin
        a = wr_addr[c*ADDR_W +: ADDR_W];
        e_drop[c] = 1'b0;
        if (wr_en[c]) begin
          if (bz || a >= 32'(ROWS*COLS)) begin
            e_drop[c] = 1'b1;
          end else begin
            ai = int'(a);
            m_mem[c][ai % ROWS][ai / ROWS] = wr_data[c*DATA_W +: DATA_W];
            m_dirty[c][ai % ROWS] = 1'b1;
          end
        end
      end
      if (scroll_en && int'(scroll_ch) < NUM_CH && int'(scroll_base) < ROWS)
        m_base[scroll_ch] = int'(scroll_base);
      if (bz) begin
        for (int c = 0; c < NUM_CH; c++) begin
          for (int k = 0; k < COLS; k++) m_mem[c][clr_idx][k] = '0;
          m_dirty[c][clr_idx] = 1'b0;
        end
        clr_idx++;
        clr_left--;
      end else if (clear_req) begin
        clr_left = ROWS; clr_idx = 0;
      end
    end
    e_busy = (clr_left > 0);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("rd_valid",  OW'(rd_valid),  OW'(e_valid));
    chk("ram_out",   ram_out,        e_ram);
    chk("dirty_out", OW'(dirty_out), OW'(e_dirty));
    chk("wr_drop",   OW'(wr_drop),   OW'(e_drop));
    chk("busy",      OW'(busy),      OW'(e_busy));
  endtask

  task automatic idle_in();
    wr_en = '0; rd_en = 1'b0; scroll_en = 1'b0; clear_req = 1'b0;
  endtask

  task automatic set_wr(input int c, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wr_en[c] = 1'b1;
    wr_addr[c*ADDR_W +: ADDR_W] = a;
    wr_data[c*DATA_W +: DATA_W] = d;
  endtask

  task automatic set_rd(input int r);
    rd_en = 1'b1;
    rd_row = ROW_W'(r);
  endtask

  initial begin
    for (int c = 0; c < NUM_CH; c++)
      for (int r = 0; r < ROWS; r++)
        for (int k = 0; k < COLS; k++) m_mem[c][r][k] = '0;
    clr_left = ROWS; clr_idx = 0;

    // Reset and the post-reset clear sweep
    idle_in(); rst = 1'b1;
    step(); step();
    rst = 1'b0;
    repeat (ROWS) step();
    chk("busy_after_clear", OW'(busy), OW'(1'b0));
    set_rd(5); step(); idle_in();
    chk("row5_zero", ram_out, '0);

    // Column split on channel 2
    set_wr(2, 3, 32'hDEADBEEF); step(); idle_in();
    set_wr(2, 49, 32'h12345678); step(); idle_in();
    set_rd(3); step();
    chk("colsplit_data", OW'(ram_out[RB-1:0]), OW'(64'h12345678_DEADBEEF));
    chk("colsplit_dirty", OW'(dirty_out[2]), OW'(1'b1));
    step(); idle_in();
    chk("colsplit_redirty", OW'(dirty_out[2]), OW'(1'b0));

    // Out-of-range write, then a write during a requested clear
    set_wr(0, 92, 32'hFFFF0000); step(); idle_in();
    chk("oor_drop", OW'(wr_drop), OW'(3'b001));
    set_rd(0); step(); idle_in();
    chk("oor_drop_end", OW'(wr_drop), OW'(3'b000));
    clear_req = 1'b1; step(); idle_in();
    set_wr(1, 10, 32'h55); step(); idle_in();
    chk("clear_drop", OW'(wr_drop), OW'(3'b010));
    for (int i = 0; i < 100 && clr_left > 0; i++) step();

    // Scroll wrap on channel 1
    scroll_en = 1'b1; scroll_ch = 2'd1; scroll_base = 6'd44; step(); idle_in();
    set_wr(1, 1, 32'hA5); step(); idle_in();
    set_rd(3); step();
    chk("scroll_wrap", OW'(ram_out[RB +: DATA_W]), OW'(32'hA5));
    set_rd(46); step(); idle_in();
    chk("row46_zero", ram_out, '0);
    chk("row46_valid", OW'(rd_valid), OW'(1'b1));

    // Read/write collision on channel 0 row 7
    set_wr(0, 7, 32'h1); step(); idle_in();
    set_wr(0, 7, 32'h2); set_rd(7); step(); idle_in();
    chk("coll_old", OW'(ram_out[2*RB +: DATA_W]), OW'(32'h1));
    chk("coll_dirty", OW'(dirty_out[0]), OW'(1'b1));
    set_rd(7); step();
    chk("coll_new", OW'(ram_out[2*RB +: DATA_W]), OW'(32'h2));
    chk("coll_dirty_kept", OW'(dirty_out[0]), OW'(1'b1));
    step(); idle_in();
    chk("coll_dirty_clr", OW'(dirty_out[0]), OW'(1'b0));

    // Reset in the middle of a requested clear restarts the full sweep
    clear_req = 1'b1; step(); idle_in();
    repeat (20) step();
    rst = 1'b1; step(); rst = 1'b0;
    repeat (ROWS - 1) step();
    chk("midclr_still_busy", OW'(busy), OW'(1'b1));
    step();
    chk("midclr_done", OW'(busy), OW'(1'b0));

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        wr_en[c] = ($urandom_range(0, 2) == 0);
        wr_addr[c*ADDR_W +: ADDR_W] = ($urandom_range(0, 15) == 0) ? $urandom : $urandom_range(0, ROWS*COLS + 4);
        wr_data[c*DATA_W +: DATA_W] = $urandom;
      end
      rd_en       = ($urandom_range(0, 1) == 1);
      rd_row      = ROW_W'($urandom_range(0, ROWS + 1));
      scroll_en   = ($urandom_range(0, 7) == 0);
      scroll_ch   = CH_W'($urandom_range(0, 3));
      scroll_base = ROW_W'($urandom_range(0, ROWS + 1));
      clear_req   = ($urandom_range(0, 99) == 0);
      step();
    end
    idle_in();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
